nn_comm_controller: RTL and testbench



---
 rtl/nn_comm_pkg.sv | 33 +++
 rtl/nn_comm_if.sv | 35 +++
 rtl/nn_byte_timeout.sv | 48 ++++
 rtl/nn_comm_controller.sv | 271 +++++++++++++++++++++++++++
 tb/tb_nn_comm_controller.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/nn_comm_pkg.sv
// ----------------------------------------------------------------------------
// nn_comm_pkg
// Shared definitions for the perceptron packet controller:
//   - request / reply opcodes carried as the first byte of every packet
//   - FSM state encoding (the numeric value is exported on cont_state)
//   - bytes_per_word(): bytes needed to carry one FP_WIDTH-bit word
// ----------------------------------------------------------------------------
package nn_comm_pkg;

    // Request opcodes
    localparam logic [7:0] OP_READ          = 8'd5;
    localparam logic [7:0] OP_WRITE_WEIGHTS = 8'd50;
    localparam logic [7:0] OP_WRITE_INPUTS  = 8'd51;

    // Reply opcodes
    localparam logic [7:0] OP_READ_RESPONSE = 8'd100;
    localparam logic [7:0] OP_OK            = 8'd101;
    localparam logic [7:0] OP_ERR           = 8'd102;

    typedef enum logic [4:0] {
        ST_IDLE       = 5'd0,
        ST_RX_PAYLOAD = 5'd1,
        ST_COMMIT     = 5'd2,
        ST_TX_START   = 5'd3,
        ST_TX_WAIT    = 5'd4,
        ST_TX_NEXT    = 5'd5
    } state_e;

    function automatic int bytes_per_word(input int fp_width);
        return (fp_width + 7) / 8;
    endfunction

endpackage

// File: rtl/nn_comm_if.sv
// ----------------------------------------------------------------------------
// nn_comm_if
// Byte-level link between the packet controller and a UART.
//   rx_data  [7:0] received byte            (UART -> controller)
//   rx_valid       one-cycle pulse, rx_data valid
//   tx_data  [7:0] byte to transmit         (controller -> UART)
//   tx_start       transmit request, held until tx_busy is seen
//   tx_busy        UART transmitter busy
// Modports: master = controller side, slave = UART side.
// ----------------------------------------------------------------------------
interface nn_comm_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_busy,
        output tx_data,
        output tx_start
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_busy,
        input  tx_data,
        input  tx_start
    );

endinterface

// File: rtl/nn_byte_timeout.sv
// ----------------------------------------------------------------------------
// nn_byte_timeout
// Inter-byte timeout: loadable down-counter.
//   clk, rst_n   clock, asynchronous active-low reset
//   reload_i     reload to TIMEOUT_CYCLES-1 (a byte arrived); beats expiry
//   enable_i     count down while high
//   expired_o    one-cycle pulse TIMEOUT_CYCLES enabled cycles after reload
// The counter reloads itself on expiry so expired_o cannot stay high.
// ----------------------------------------------------------------------------
module nn_byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign expired_o = enable_i && !reload_i && (cnt_q == '0);

    // NOTE: combinational blocks assign every output a default first and use
    // blocking '='; a path that leaves cnt_d unassigned would infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (reload_i || expired_o) begin
            cnt_d = LOAD_VAL;
        end else if (enable_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nn_comm_controller.sv
// ----------------------------------------------------------------------------
// nn_comm_controller
// Byte-level packet controller between a UART and an N-input fixed-point
// perceptron register set.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          nn_comm_if.master (rx_data/rx_valid in, tx_data/tx_start out,
//                tx_busy in)
//   result       perceptron output, FP_WIDTH bits
//   weights      weight k at [k*FP_WIDTH +: FP_WIDTH]
//   inputs       same packing as weights
//   update       one-cycle pulse the cycle after an inputs commit
//   cont_state   current FSM state code
// Writes land in a shadow buffer and are copied in a single COMMIT cycle, so
// the perceptron never sees a half-written vector. Reads are snapshotted into
// the TX buffer before the first byte leaves.
// Optional macro NN_COMM_CHECKSUM_EN: write packets carry a trailing XOR byte
// (over opcode and payload; mismatch -> ERR, no commit) and read responses
// append an XOR byte over all response bytes.
// ----------------------------------------------------------------------------
module nn_comm_controller
    import nn_comm_pkg::*;
#(
    parameter int unsigned N_INPUTS        = 2,
    parameter int unsigned FP_WIDTH        = 16,
    parameter int unsigned CLOCK_FREQUENCY = 12000000,
    parameter int unsigned UART_BAUD_RATE  = 9600,
    parameter int unsigned TIMEOUT_BYTES   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nn_comm_if.master                    bus,
    input  logic [FP_WIDTH-1:0]          result,
    output logic [N_INPUTS*FP_WIDTH-1:0] weights,
    output logic [N_INPUTS*FP_WIDTH-1:0] inputs,
    output logic                         update,
    output logic [4:0]                   cont_state
);

    localparam int BYTES_PER_WORD = bytes_per_word(FP_WIDTH);
    localparam int WORD_BITS      = BYTES_PER_WORD * 8;
    localparam int PAYLOAD_BYTES  = N_INPUTS * BYTES_PER_WORD;
    localparam int SH_W           = PAYLOAD_BYTES * 8;
    localparam int VEC_W          = N_INPUTS * FP_WIDTH;
`ifdef NN_COMM_CHECKSUM_EN
    localparam int CK_BYTES       = 1;
`else
    localparam int CK_BYTES       = 0;
`endif
    localparam int RX_BYTES       = PAYLOAD_BYTES + CK_BYTES;
    localparam int READ_LEN       = 1 + (N_INPUTS + 1) * BYTES_PER_WORD;
    localparam int TX_MAX         = READ_LEN + CK_BYTES;
    localparam int IDX_W          = $clog2(TX_MAX + 1);
    localparam int CNT_W          = $clog2(RX_BYTES + 1);

    localparam longint unsigned TIMEOUT_L =
        longint'(TIMEOUT_BYTES) * 64'd10 * longint'(CLOCK_FREQUENCY) / longint'(UART_BAUD_RATE);
    localparam int unsigned TIMEOUT_CYCLES = 32'(TIMEOUT_L);

    state_e                  state_q;
    logic [7:0]              opcode_q;
    logic [CNT_W-1:0]        rx_cnt_q;
    logic [SH_W-1:0]         shadow_q;
    logic [TX_MAX-1:0][7:0]  tx_buf_q;
    logic [IDX_W-1:0]        tx_left_q;
    logic [7:0]              tx_data_q;
    logic                    tx_start_q;
    logic [VEC_W-1:0]        weights_q;
    logic [VEC_W-1:0]        inputs_q;
    logic                    update_q;
    logic                    commit_ok;
    logic                    timeout_expired;

`ifdef NN_COMM_CHECKSUM_EN
    logic [7:0]              rx_xor_q;
    logic                    cksum_bad_q;
    assign commit_ok = !cksum_bad_q;
`else
    assign commit_ok = 1'b1;
`endif

    nn_byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .reload_i  (bus.rx_valid),
        .enable_i  (state_q == ST_RX_PAYLOAD),
        .expired_o (timeout_expired)
    );

    // Single-byte reply frame (OK / ERR).
    function automatic logic [TX_MAX-1:0][7:0] one_byte(input logic [7:0] b);
        one_byte    = '0;
        one_byte[0] = b;
    endfunction

    // Read-response frame built from live registers; latched whole on READ.
    logic [TX_MAX-1:0][7:0] read_frame;
    logic [WORD_BITS-1:0]   word_pad;

    always_comb begin
        read_frame    = '0;
        word_pad      = '0;
        read_frame[0] = OP_READ_RESPONSE;
        for (int k = 0; k < N_INPUTS; k++) begin
            word_pad                 = '0;
            word_pad[FP_WIDTH-1:0]   = weights_q[k*FP_WIDTH +: FP_WIDTH];
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                read_frame[1 + k*BYTES_PER_WORD + b] = word_pad[(BYTES_PER_WORD-1-b)*8 +: 8];
            end
        end
        word_pad               = '0;
        word_pad[FP_WIDTH-1:0] = result;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            read_frame[1 + N_INPUTS*BYTES_PER_WORD + b] = word_pad[(BYTES_PER_WORD-1-b)*8 +: 8];
        end
`ifdef NN_COMM_CHECKSUM_EN
        for (int i = 0; i < READ_LEN; i++) begin
            read_frame[READ_LEN] = read_frame[READ_LEN] ^ read_frame[i];
        end
`endif
    end

    // Byte shift into the shadow buffer: first payload byte ends up on top,
    // so word 0 occupies the most significant word slot.
    logic [SH_W+7:0]  shadow_ext;
    logic [SH_W-1:0]  shadow_shift;
    logic [VEC_W-1:0] commit_words;

    always_comb begin
        shadow_ext   = {shadow_q, bus.rx_data};
        shadow_shift = shadow_ext[SH_W-1:0];
        commit_words = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            // Only the low FP_WIDTH bits of each word are kept; padding drops.
            commit_words[k*FP_WIDTH +: FP_WIDTH] =
                shadow_q[(N_INPUTS-1-k)*WORD_BITS +: FP_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow and TX buffers are reset like ordinary flops
            // because their post-reset contents are defined as zero.
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            rx_cnt_q    <= '0;
            shadow_q    <= '0;
            tx_buf_q    <= '0;
            tx_left_q   <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            weights_q   <= '0;
            inputs_q    <= '0;
            update_q    <= 1'b0;
`ifdef NN_COMM_CHECKSUM_EN
            rx_xor_q    <= '0;
            cksum_bad_q <= 1'b0;
`endif
        end else begin
            update_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == OP_READ) begin
                            tx_buf_q   <= read_frame;
                            tx_left_q  <= IDX_W'(TX_MAX);
                            tx_data_q  <= read_frame[0];
                            tx_start_q <= 1'b1;
                            state_q    <= ST_TX_START;
                        end else if (bus.rx_data == OP_WRITE_WEIGHTS ||
                                     bus.rx_data == OP_WRITE_INPUTS) begin
                            opcode_q <= bus.rx_data;
                            rx_cnt_q <= '0;
`ifdef NN_COMM_CHECKSUM_EN
                            rx_xor_q <= bus.rx_data;
`endif
                            state_q  <= ST_RX_PAYLOAD;
                        end else begin
                            tx_buf_q   <= one_byte(OP_ERR);
                            tx_left_q  <= IDX_W'(1);
                            tx_data_q  <= OP_ERR;
                            tx_start_q <= 1'b1;
                            state_q    <= ST_TX_START;
                        end
                    end
                end

                ST_RX_PAYLOAD: begin
                    // A byte in the expiry cycle wins: the timer also reloads.
                    if (bus.rx_valid) begin
                        if (rx_cnt_q < CNT_W'(PAYLOAD_BYTES)) begin
                            shadow_q <= shadow_shift;
                        end
`ifdef NN_COMM_CHECKSUM_EN
                        rx_xor_q <= rx_xor_q ^ bus.rx_data;
                        if (rx_cnt_q == CNT_W'(RX_BYTES - 1)) begin
                            cksum_bad_q <= (rx_xor_q != bus.rx_data);
                        end
`endif
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                        if (rx_cnt_q == CNT_W'(RX_BYTES - 1)) begin
                            state_q <= ST_COMMIT;
                        end
                    end else if (timeout_expired) begin
                        shadow_q   <= '0;
                        tx_buf_q   <= one_byte(OP_ERR);
                        tx_left_q  <= IDX_W'(1);
                        tx_data_q  <= OP_ERR;
                        tx_start_q <= 1'b1;
                        state_q    <= ST_TX_START;
                    end
                end

                ST_COMMIT: begin
                    tx_left_q  <= IDX_W'(1);
                    tx_start_q <= 1'b1;
                    state_q    <= ST_TX_START;
                    if (commit_ok) begin
                        if (opcode_q == OP_WRITE_INPUTS) begin
                            inputs_q <= commit_words;
                            update_q <= 1'b1;
                        end else begin
                            weights_q <= commit_words;
                        end
                        tx_buf_q  <= one_byte(OP_OK);
                        tx_data_q <= OP_OK;
                    end else begin
                        tx_buf_q  <= one_byte(OP_ERR);
                        tx_data_q <= OP_ERR;
                    end
                end

                ST_TX_START: begin
                    if (bus.tx_busy) begin
                        tx_start_q <= 1'b0;
                        state_q    <= ST_TX_WAIT;
                    end
                end

                ST_TX_WAIT: begin
                    if (!bus.tx_busy) begin
                        state_q <= ST_TX_NEXT;
                    end
                end

                ST_TX_NEXT: begin
                    if (tx_left_q > IDX_W'(1)) begin
                        tx_buf_q   <= tx_buf_q >> 8;
                        tx_data_q  <= tx_buf_q[1];
                        tx_left_q  <= tx_left_q - 1'b1;
                        tx_start_q <= 1'b1;
                        state_q    <= ST_TX_START;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign weights      = weights_q;
    assign inputs       = inputs_q;
    assign update       = update_q;
    assign cont_state   = state_q;

endmodule

// File: tb/tb_nn_comm_controller.sv
// ----------------------------------------------------------------------------
// tb_nn_comm_controller
// Directed bench for nn_comm_controller in its default build (no checksum).
// Instance A: N_INPUTS=2, FP_WIDTH=16. Instance B: N_INPUTS=3, FP_WIDTH=12.
// Both run with CLOCK_FREQUENCY=96000 and UART_BAUD_RATE=9600, so the
// inter-byte timeout is 4*10*96000/9600 = 400 cycles.
// A small UART model captures each requested byte and holds tx_busy for
// three cycles.
// ----------------------------------------------------------------------------
module tb_nn_comm_controller;

    localparam int unsigned CLK_HZ   = 96000;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned TO_BYTES = 4;
    localparam int          TIMEOUT  = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nn_comm_if bus_a ();
    nn_comm_if bus_b ();

    logic [15:0] result_a;
    logic [31:0] weights_a, inputs_a;
    logic        update_a;
    logic [4:0]  state_a;

    logic [11:0] result_b;
    logic [35:0] weights_b, inputs_b;
    logic        update_b;
    logic [4:0]  state_b;

    nn_comm_controller #(
        .N_INPUTS        (2),
        .FP_WIDTH        (16),
        .CLOCK_FREQUENCY (CLK_HZ),
        .UART_BAUD_RATE  (BAUD),
        .TIMEOUT_BYTES   (TO_BYTES)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_a),
        .result     (result_a),
        .weights    (weights_a),
        .inputs     (inputs_a),
        .update     (update_a),
        .cont_state (state_a)
    );

    nn_comm_controller #(
        .N_INPUTS        (3),
        .FP_WIDTH        (12),
        .CLOCK_FREQUENCY (CLK_HZ),
        .UART_BAUD_RATE  (BAUD),
        .TIMEOUT_BYTES   (TO_BYTES)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_b),
        .result     (result_b),
        .weights    (weights_b),
        .inputs     (inputs_b),
        .update     (update_b),
        .cont_state (state_b)
    );

    // UART transmitter models
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int busy_a, busy_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_a <= 0;
        end else if (busy_a != 0) begin
            busy_a <= busy_a - 1;
        end else if (bus_a.tx_start) begin
            q_a.push_back(bus_a.tx_data);
            busy_a <= 3;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_b <= 0;
        end else if (busy_b != 0) begin
            busy_b <= busy_b - 1;
        end else if (bus_b.tx_start) begin
            q_b.push_back(bus_b.tx_data);
            busy_b <= 3;
        end
    end

    assign bus_a.tx_busy = (busy_a != 0);
    assign bus_b.tx_busy = (busy_b != 0);

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit sel_b, input logic [7:0] b);
        @(negedge clk);
        if (sel_b) begin
            bus_b.rx_data  = b;
            bus_b.rx_valid = 1'b1;
        end else begin
            bus_a.rx_data  = b;
            bus_a.rx_valid = 1'b1;
        end
        @(negedge clk);
        bus_a.rx_valid = 1'b0;
        bus_b.rx_valid = 1'b0;
    endtask

    // Wait (bounded) for a complete reply, then compare it byte by byte.
    // Byte i of the reply is exp[(len-1-i)*8 +: 8], i.e. written MSB-first.
    task automatic expect_reply(input bit sel_b, input string tag, input int len,
                                input logic [127:0] exp);
        int n;
        logic [7:0] got;
        for (int i = 0; i < 3000; i++) begin
            n = sel_b ? q_b.size() : q_a.size();
            if (n >= len && (sel_b ? state_b : state_a) == 5'd0) break;
            @(negedge clk);
        end
        n = sel_b ? q_b.size() : q_a.size();
        check({tag, ".len"}, 64'(n), 64'(len));
        for (int i = 0; i < len && i < n; i++) begin
            got = sel_b ? q_b[i] : q_a[i];
            check($sformatf("%s[%0d]", tag, i), 64'(got), 64'(exp[(len-1-i)*8 +: 8]));
        end
        if (sel_b) q_b.delete();
        else       q_a.delete();
    endtask

    initial begin
        bus_a.rx_data  = '0;
        bus_a.rx_valid = 1'b0;
        bus_b.rx_data  = '0;
        bus_b.rx_valid = 1'b0;
        result_a = 16'h1000;
        result_b = 12'hABC;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.weights", 64'(weights_a), 64'h0);
        check("rst.inputs", 64'(inputs_a), 64'h0);
        check("rst.update", 64'(update_a), 64'h0);
        check("rst.state", 64'(state_a), 64'h0);
        check("rst.tx_start", 64'(bus_a.tx_start), 64'h0);
        check("rst.tx_data", 64'(bus_a.tx_data), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read after reset
        send(0, 8'd5);
        expect_reply(0, "read0", 7, 128'h64_0000_0000_1000);

        // Write weights, then read them back
        send(0, 8'd50); send(0, 8'h15); send(0, 8'hAA); send(0, 8'hFC); send(0, 8'h33);
        expect_reply(0, "wr_w", 1, 128'h65);
        check("wr_w.weights", 64'(weights_a), 64'hFC33_15AA);
        send(0, 8'd5);
        expect_reply(0, "read1", 7, 128'h64_15AA_FC33_1000);

        // Write inputs with commit / update timing
        send(0, 8'd51); send(0, 8'hE0); send(0, 8'h00); send(0, 8'h20); send(0, 8'h0F);
        check("wr_i.commit_state", 64'(state_a), 64'd2);
        check("wr_i.commit_update", 64'(update_a), 64'h0);
        check("wr_i.commit_txstart", 64'(bus_a.tx_start), 64'h0);
        check("wr_i.commit_inputs", 64'(inputs_a), 64'h0);
        @(negedge clk);
        check("wr_i.post_state", 64'(state_a), 64'd3);
        check("wr_i.post_update", 64'(update_a), 64'h1);
        check("wr_i.post_txstart", 64'(bus_a.tx_start), 64'h1);
        check("wr_i.inputs", 64'(inputs_a), 64'h200F_E000);
        @(negedge clk);
        check("wr_i.update_drop", 64'(update_a), 64'h0);
        expect_reply(0, "wr_i", 1, 128'h65);

        // Unknown opcode
        send(0, 8'd77);
        expect_reply(0, "badop", 1, 128'h66);
        check("badop.weights", 64'(weights_a), 64'hFC33_15AA);
        check("badop.inputs", 64'(inputs_a), 64'h200F_E000);

        // Inter-byte timeout, exact expiry point
        send(0, 8'd50); send(0, 8'h15); send(0, 8'hAA);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("to.before", 64'(state_a), 64'd1);
        @(negedge clk);
        check("to.after", 64'(state_a), 64'd3);
        expect_reply(0, "to", 1, 128'h66);
        check("to.weights", 64'(weights_a), 64'hFC33_15AA);
        send(0, 8'd50); send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
        expect_reply(0, "to.rewrite", 1, 128'h65);
        check("to.rewrite_weights", 64'(weights_a), 64'h0304_0102);

        // Instance B: 3 x 12-bit words, padding nibbles ignored / sent as zero
        send(1, 8'd51); send(1, 8'hF8); send(1, 8'h00); send(1, 8'h00);
        send(1, 8'h01); send(1, 8'h0F); send(1, 8'hFF);
        expect_reply(1, "b.wr_i", 1, 128'h65);
        check("b.inputs", 64'(inputs_b), 64'hF_FF00_1800);
        send(1, 8'd50); send(1, 8'hF8); send(1, 8'h00); send(1, 8'h00);
        send(1, 8'h01); send(1, 8'h0F); send(1, 8'hFF);
        expect_reply(1, "b.wr_w", 1, 128'h65);
        check("b.weights", 64'(weights_b), 64'hF_FF00_1800);
        send(1, 8'd5);
        expect_reply(1, "b.read", 9, 128'h64_0800_0001_0FFF_0ABC);

        // Reset mid-packet aborts without a reply
        send(0, 8'd51); send(0, 8'h11);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.state", 64'(state_a), 64'd0);
        check("abort.inputs", 64'(inputs_a), 64'h0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("abort.no_reply", 64'(q_a.size()), 64'd0);
        check("abort.idle", 64'(state_a), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
